// File: rtl/alu_arbiter_if.sv
// rtl/alu_arbiter_if.sv - request/response bundle between two requesters and the shared ALU arbiter
interface alu_arbiter_if;
  logic        req0_valid;
  logic        req0_ready;
  logic [31:0] req0_a;
  logic [31:0] req0_b;
  logic [4:0]  req0_op;
  logic        req1_valid;
  logic        req1_ready;
  logic [31:0] req1_a;
  logic [31:0] req1_b;
  logic [4:0]  req1_op;
  logic        rsp0_valid;
  logic        rsp0_ready;
  logic        rsp1_valid;
  logic        rsp1_ready;
  logic [31:0] rsp_result;
  logic        rsp_flag;
  logic        rsp_err;

  modport master (
    output req0_valid, req0_a, req0_b, req0_op,
    output req1_valid, req1_a, req1_b, req1_op,
    output rsp0_ready, rsp1_ready,
    input  req0_ready, req1_ready,
    input  rsp0_valid, rsp1_valid, rsp_result, rsp_flag, rsp_err
  );

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_op,
    input  req1_valid, req1_a, req1_b, req1_op,
    input  rsp0_ready, rsp1_ready,
    output req0_ready, req1_ready,
    output rsp0_valid, rsp1_valid, rsp_result, rsp_flag, rsp_err
  );
endinterface

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin arbiter sharing one RV32 ALU between two requesters
module alu_arbiter #(
  parameter bit PRIORITY_INIT = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  alu_arbiter_if.slave bus,
  output logic         busy,
  output logic         owner
);

  localparam logic [4:0] OP_ADD = 5'b00000;
  localparam logic [4:0] OP_SUB = 5'b01000;
  localparam logic [4:0] OP_XOR = 5'b00100;
  localparam logic [4:0] OP_OR  = 5'b00110;
  localparam logic [4:0] OP_AND = 5'b00111;
  localparam logic [4:0] OP_SRA = 5'b01101;
  localparam logic [4:0] OP_SRL = 5'b00101;
  localparam logic [4:0] OP_SLL = 5'b00001;
  localparam logic [4:0] OP_LTS = 5'b11100;
  localparam logic [4:0] OP_LTU = 5'b11110;
  localparam logic [4:0] OP_GES = 5'b11101;
  localparam logic [4:0] OP_GEU = 5'b11111;
  localparam logic [4:0] OP_EQ  = 5'b11000;
  localparam logic [4:0] OP_NE  = 5'b11001;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      state_q;
  state_t      state_d;
  logic        last_grant_q;
  logic        owner_q;
  logic        winner;
  logic        accept;
  logic        rsp_hs;
  logic        big_shift;
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic [4:0]  op_q;
  logic [31:0] res_q;
  logic        flag_q;
  logic        err_q;
  logic [31:0] alu_res;
  logic [31:0] sra_val;
  logic        alu_legal;

  // A tie goes to the port that did not win last time, so neither side starves.
  always_comb begin
    winner = 1'b0;
    if (bus.req0_valid && bus.req1_valid) begin
      winner = ~last_grant_q;
    end else if (bus.req1_valid) begin
      winner = 1'b1;
    end
  end

  assign accept = (state_q == IDLE) && !rst && (bus.req0_valid || bus.req1_valid);
  assign rsp_hs = owner_q ? bus.rsp1_ready : bus.rsp0_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = EXEC;
      EXEC:    state_d = RESP;
      RESP:    if (rsp_hs) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.req0_ready = accept && !winner;
    bus.req1_ready = accept && winner;
    bus.rsp0_valid = (state_q == RESP) && !owner_q;
    bus.rsp1_valid = (state_q == RESP) && owner_q;
    busy           = (state_q != IDLE);
  end

  assign bus.rsp_result = res_q;
  assign bus.rsp_flag   = flag_q;
  assign bus.rsp_err    = err_q;
  assign owner          = owner_q;

  // Shift amount is the whole of B: anything at or above 32 saturates.
  assign big_shift = (b_q[31:5] != 27'd0);
  assign sra_val   = $signed(a_q) >>> b_q[4:0];

  always_comb begin
    alu_res   = 32'd0;
    alu_legal = 1'b1;
    case (op_q)
      OP_ADD:  alu_res = a_q + b_q;
      OP_SUB:  alu_res = a_q - b_q;
      OP_XOR:  alu_res = a_q ^ b_q;
      OP_OR:   alu_res = a_q | b_q;
      OP_AND:  alu_res = a_q & b_q;
      OP_SLL:  alu_res = big_shift ? 32'd0 : (a_q << b_q[4:0]);
      OP_SRL:  alu_res = big_shift ? 32'd0 : (a_q >> b_q[4:0]);
      OP_SRA:  alu_res = big_shift ? {32{a_q[31]}} : sra_val;
      OP_LTS:  alu_res = {31'd0, $signed(a_q) <  $signed(b_q)};
      OP_LTU:  alu_res = {31'd0, a_q <  b_q};
      OP_GES:  alu_res = {31'd0, $signed(a_q) >= $signed(b_q)};
      OP_GEU:  alu_res = {31'd0, a_q >= b_q};
      OP_EQ:   alu_res = {31'd0, a_q == b_q};
      OP_NE:   alu_res = {31'd0, a_q != b_q};
      default: alu_legal = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q          <= 32'd0;
      b_q          <= 32'd0;
      op_q         <= 5'd0;
      owner_q      <= PRIORITY_INIT;
      last_grant_q <= ~PRIORITY_INIT;
      res_q        <= 32'd0;
      flag_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      if (accept) begin
        a_q          <= winner ? bus.req1_a  : bus.req0_a;
        b_q          <= winner ? bus.req1_b  : bus.req0_b;
        op_q         <= winner ? bus.req1_op : bus.req0_op;
        owner_q      <= winner;
        last_grant_q <= winner;
      end
      if (state_q == EXEC) begin
        res_q  <= alu_legal ? alu_res : 32'd0;
        flag_q <= alu_legal && op_q[4] && alu_res[0];
        err_q  <= ~alu_legal;
      end
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - table vectors, corner sequences and random scoreboard run for alu_arbiter
module tb_alu_arbiter;

  localparam logic [4:0] OP_ADD = 5'b00000;
  localparam logic [4:0] OP_SUB = 5'b01000;
  localparam logic [4:0] OP_XOR = 5'b00100;
  localparam logic [4:0] OP_OR  = 5'b00110;
  localparam logic [4:0] OP_AND = 5'b00111;
  localparam logic [4:0] OP_SRA = 5'b01101;
  localparam logic [4:0] OP_SRL = 5'b00101;
  localparam logic [4:0] OP_SLL = 5'b00001;
  localparam logic [4:0] OP_LTS = 5'b11100;
  localparam logic [4:0] OP_LTU = 5'b11110;
  localparam logic [4:0] OP_GES = 5'b11101;
  localparam logic [4:0] OP_GEU = 5'b11111;
  localparam logic [4:0] OP_EQ  = 5'b11000;
  localparam logic [4:0] OP_NE  = 5'b11001;

  typedef struct packed {
    logic [31:0] result;
    logic        flag;
    logic        err;
  } exp_t;

  typedef struct packed {
    logic port;
    exp_t e;
  } sb_t;

  typedef struct {
    logic        port;
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    exp_t        e;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  logic busy;
  logic owner;

  always #5 clk = ~clk;

  alu_arbiter_if bus ();

  alu_arbiter #(.PRIORITY_INIT(1'b0)) dut (
    .clk   (clk),
    .rst   (rst),
    .bus   (bus),
    .busy  (busy),
    .owner (owner)
  );

  int   tests = 0;
  int   fails = 0;
  int   grants = 0;
  sb_t  sb[$];
  exp_t pend[2];
  logic hs_seen[2];
  logic model_last;
  vec_t vecs[$];
  logic [4:0] legal_ops[14];
  logic [4:0] bad_ops[3];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: actual=0x%08h required=0x%08h", name, act, req);
    end
  endtask

  function automatic exp_t model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t        r;
    logic [63:0] w;
    r = '0;
    case (op)
      OP_ADD: r.result = a + b;
      OP_SUB: r.result = a + ~b + 32'd1;
      OP_XOR: r.result = a ^ b;
      OP_OR:  r.result = a | b;
      OP_AND: r.result = a & b;
      OP_SLL: begin w = {32'd0, a} << b; r.result = w[31:0]; end
      OP_SRL: begin w = {32'd0, a} >> b; r.result = w[31:0]; end
      OP_SRA: begin w = $signed({{32{a[31]}}, a}) >>> b; r.result = w[31:0]; end
      OP_LTS: r.result = ($signed(a) <  $signed(b)) ? 32'd1 : 32'd0;
      OP_LTU: r.result = (a <  b) ? 32'd1 : 32'd0;
      OP_GES: r.result = ($signed(a) >= $signed(b)) ? 32'd1 : 32'd0;
      OP_GEU: r.result = (a >= b) ? 32'd1 : 32'd0;
      OP_EQ:  r.result = (a == b) ? 32'd1 : 32'd0;
      OP_NE:  r.result = (a != b) ? 32'd1 : 32'd0;
      default: r.err = 1'b1;
    endcase
    r.flag = op[4] && !r.err && r.result[0];
    return r;
  endfunction

  function automatic vec_t mk(input logic port, input logic [4:0] op, input logic [31:0] a,
                              input logic [31:0] b, input logic [31:0] res, input logic flag,
                              input logic err);
    vec_t v;
    v.port     = port;
    v.op       = op;
    v.a        = a;
    v.b        = b;
    v.e.result = res;
    v.e.flag   = flag;
    v.e.err    = err;
    return v;
  endfunction

  task automatic drive(input logic port, input logic v, input logic [4:0] op,
                       input logic [31:0] a, input logic [31:0] b);
    if (port) begin
      bus.req1_valid = v; bus.req1_op = op; bus.req1_a = a; bus.req1_b = b;
    end else begin
      bus.req0_valid = v; bus.req0_op = op; bus.req0_a = a; bus.req0_b = b;
    end
  endtask

  task automatic rand_stim(input logic port);
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    if ($urandom_range(0, 9) == 0) op = bad_ops[$urandom_range(0, 2)];
    else                           op = legal_ops[$urandom_range(0, 13)];
    a = $urandom;
    b = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 40)) : $urandom;
    if ($urandom_range(0, 4) == 0) b = a;
    drive(port, 1'b1, op, a, b);
    pend[port] = model(op, a, b);
  endtask

  task automatic wait_ready(input logic port, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (port ? bus.req1_ready : bus.req0_ready) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic drain(input string name);
    logic ok;
    ok = 1'b0;
    bus.rsp0_ready = 1'b1;
    bus.rsp1_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!busy && sb.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    check(name, {31'd0, ok}, 32'd1);
  endtask

  // Single isolated transaction: ready in the first cycle, response two cycles later.
  task automatic run_vec(input vec_t v);
    drive(v.port, 1'b1, v.op, v.a, v.b);
    pend[v.port] = v.e;
    @(negedge clk);
    check("vec_ready", {31'd0, v.port ? bus.req1_ready : bus.req0_ready}, 32'd1);
    @(posedge clk);
    #1 drive(v.port, 1'b0, v.op, v.a, v.b);
    @(negedge clk);
    check("vec_exec_busy", {31'd0, busy}, 32'd1);
    check("vec_exec_no_rsp", {31'd0, v.port ? bus.rsp1_valid : bus.rsp0_valid}, 32'd0);
    @(negedge clk);
    check("vec_rsp_valid", {31'd0, v.port ? bus.rsp1_valid : bus.rsp0_valid}, 32'd1);
    check("vec_other_idle", {31'd0, v.port ? bus.rsp0_valid : bus.rsp1_valid}, 32'd0);
    check("vec_owner", {31'd0, owner}, {31'd0, v.port});
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: expectations enter on request handshake and leave on response handshake.
  always @(negedge clk) begin
    logic wp;
    logic ew;
    logic rp;
    sb_t  item;
    if (rst) begin
      sb.delete();
      model_last = 1'b1;
    end else begin
      if (bus.req0_ready || bus.req1_ready) begin
        check("ready_onehot", {31'd0, bus.req0_ready && bus.req1_ready}, 32'd0);
        check("ready_while_busy", {31'd0, busy}, 32'd0);
        wp = bus.req1_ready;
        if (bus.req0_valid && bus.req1_valid) ew = ~model_last;
        else                                  ew = bus.req1_valid;
        check("grant_port", {31'd0, wp}, {31'd0, ew});
        sb.push_back('{port: wp, e: pend[wp]});
        model_last  = wp;
        hs_seen[wp] = 1'b1;
        grants++;
      end
      if (bus.rsp0_valid || bus.rsp1_valid) begin
        check("rsp_valid_onehot", {31'd0, bus.rsp0_valid && bus.rsp1_valid}, 32'd0);
      end
      if ((bus.rsp0_valid && bus.rsp0_ready) || (bus.rsp1_valid && bus.rsp1_ready)) begin
        rp = bus.rsp1_valid;
        check("sb_has_entry", {31'd0, sb.size() != 0}, 32'd1);
        if (sb.size() != 0) begin
          item = sb.pop_front();
          check("rsp_port", {31'd0, rp}, {31'd0, item.port});
          check("rsp_result", bus.rsp_result, item.e.result);
          check("rsp_flag", {31'd0, bus.rsp_flag}, {31'd0, item.e.flag});
          check("rsp_err", {31'd0, bus.rsp_err}, {31'd0, item.e.err});
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic ok;
    int   g0;

    legal_ops = '{OP_ADD, OP_SUB, OP_XOR, OP_OR, OP_AND, OP_SRA, OP_SRL,
                  OP_SLL, OP_LTS, OP_LTU, OP_GES, OP_GEU, OP_EQ, OP_NE};
    bad_ops   = '{5'b10000, 5'b00010, 5'b11010};
    hs_seen[0] = 1'b0;
    hs_seen[1] = 1'b0;
    model_last = 1'b1;

    vecs.push_back(mk(0, OP_ADD, 32'd5, 32'd7, 32'd12, 0, 0));
    vecs.push_back(mk(1, OP_ADD, 32'd1, 32'd2, 32'd3, 0, 0));
    vecs.push_back(mk(0, OP_SUB, 32'd5, 32'd7, 32'hFFFF_FFFE, 0, 0));
    vecs.push_back(mk(1, OP_XOR, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0, 0, 0));
    vecs.push_back(mk(0, OP_OR,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'hFFF0_FFF0, 0, 0));
    vecs.push_back(mk(1, OP_AND, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 0, 0));
    vecs.push_back(mk(0, OP_SLL, 32'd1, 32'd31, 32'h8000_0000, 0, 0));
    vecs.push_back(mk(0, OP_SLL, 32'd1, 32'd32, 32'd0, 0, 0));
    vecs.push_back(mk(1, OP_SRL, 32'h8000_0000, 32'd31, 32'd1, 0, 0));
    vecs.push_back(mk(0, OP_SRL, 32'hFFFF_FFFF, 32'd100, 32'd0, 0, 0));
    vecs.push_back(mk(1, OP_SRA, 32'h8000_0000, 32'd4, 32'hF800_0000, 0, 0));
    vecs.push_back(mk(0, OP_SRA, 32'h8000_0000, 32'h40, 32'hFFFF_FFFF, 0, 0));
    vecs.push_back(mk(1, OP_GES, 32'hFFFF_FFFF, 32'd1, 32'd0, 0, 0));
    vecs.push_back(mk(0, OP_GEU, 32'hFFFF_FFFF, 32'd1, 32'd1, 1, 0));
    vecs.push_back(mk(1, OP_NE,  32'd3, 32'd3, 32'd0, 0, 0));
    vecs.push_back(mk(0, 5'b10000, 32'd5, 32'd5, 32'd0, 0, 1));
    vecs.push_back(mk(0, OP_EQ,  32'd3, 32'd3, 32'd1, 1, 0));

    // Reset with both ports already requesting: tie, round-robin.
    rst = 1'b1;
    bus.rsp0_ready = 1'b1;
    bus.rsp1_ready = 1'b1;
    drive(0, 1'b1, OP_LTS, 32'hFFFF_FFFF, 32'd1);
    drive(1, 1'b1, OP_LTU, 32'hFFFF_FFFF, 32'd1);
    pend[0] = '{result: 32'd1, flag: 1'b1, err: 1'b0};
    pend[1] = '{result: 32'd0, flag: 1'b0, err: 1'b0};
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_req0_ready", {31'd0, bus.req0_ready}, 32'd0);
    check("rst_req1_ready", {31'd0, bus.req1_ready}, 32'd0);
    check("rst_rsp0_valid", {31'd0, bus.rsp0_valid}, 32'd0);
    check("rst_rsp1_valid", {31'd0, bus.rsp1_valid}, 32'd0);
    check("rst_result", bus.rsp_result, 32'd0);
    check("rst_flag", {31'd0, bus.rsp_flag}, 32'd0);
    check("rst_err", {31'd0, bus.rsp_err}, 32'd0);
    check("rst_owner", {31'd0, owner}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("tie1_port0_ready", {31'd0, bus.req0_ready}, 32'd1);
    check("tie1_port1_wait", {31'd0, bus.req1_ready}, 32'd0);
    @(posedge clk);
    #1 drive(0, 1'b1, OP_ADD, 32'd1, 32'd1);
    pend[0] = model(OP_ADD, 32'd1, 32'd1);
    wait_ready(1, ok);
    check("tie2_port1_granted", {31'd0, ok}, 32'd1);
    check("tie2_port0_wait", {31'd0, bus.req0_ready}, 32'd0);
    @(posedge clk);
    #1 drive(1, 1'b1, OP_ADD, 32'd2, 32'd2);
    pend[1] = model(OP_ADD, 32'd2, 32'd2);
    wait_ready(0, ok);
    check("tie3_port0_granted", {31'd0, ok}, 32'd1);
    check("tie3_port1_wait", {31'd0, bus.req1_ready}, 32'd0);
    @(posedge clk);
    #1 drive(0, 1'b0, OP_ADD, 32'd0, 32'd0);
    drive(1, 1'b0, OP_ADD, 32'd0, 32'd0);
    drain("tie_drain");

    @(posedge clk);
    #1;
    foreach (vecs[i]) run_vec(vecs[i]);
    drain("vec_drain");

    // Backpressure on port1 while port0 waits.
    @(posedge clk);
    #1 bus.rsp1_ready = 1'b0;
    drive(1, 1'b1, OP_SRA, 32'h8000_0000, 32'd4);
    pend[1] = '{result: 32'hF800_0000, flag: 1'b0, err: 1'b0};
    @(negedge clk);
    check("bp_port1_ready", {31'd0, bus.req1_ready}, 32'd1);
    @(posedge clk);
    #1 drive(1, 1'b0, OP_SRA, 32'd0, 32'd0);
    drive(0, 1'b1, OP_ADD, 32'd10, 32'd20);
    pend[0] = '{result: 32'd30, flag: 1'b0, err: 1'b0};
    ok = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (bus.rsp1_valid) begin
        ok = 1'b1;
        break;
      end
    end
    check("bp_rsp1_valid", {31'd0, ok}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      check("bp_result_held", bus.rsp_result, 32'hF800_0000);
      check("bp_busy", {31'd0, busy}, 32'd1);
      check("bp_no_req0_ready", {31'd0, bus.req0_ready}, 32'd0);
      check("bp_rsp1_held", {31'd0, bus.rsp1_valid}, 32'd1);
    end
    @(posedge clk);
    #1 bus.rsp1_ready = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    check("bp_idle_after", {31'd0, busy}, 32'd0);
    check("bp_port0_granted", {31'd0, bus.req0_ready}, 32'd1);
    @(posedge clk);
    #1 drive(0, 1'b0, OP_ADD, 32'd0, 32'd0);
    drain("bp_drain");

    // Reset while port1's operation is in EXEC.
    @(posedge clk);
    #1 drive(1, 1'b1, OP_ADD, 32'd5, 32'd7);
    pend[1] = model(OP_ADD, 32'd5, 32'd7);
    @(negedge clk);
    check("mid_rst_accept", {31'd0, bus.req1_ready}, 32'd1);
    @(posedge clk);
    #1 drive(1, 1'b0, OP_ADD, 32'd0, 32'd0);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    drive(1, 1'b1, OP_ADD, 32'd2, 32'd3);
    pend[1] = model(OP_ADD, 32'd2, 32'd3);
    @(negedge clk);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_rsp0", {31'd0, bus.rsp0_valid}, 32'd0);
    check("mid_rst_rsp1", {31'd0, bus.rsp1_valid}, 32'd0);
    check("mid_rst_result", bus.rsp_result, 32'd0);
    check("mid_rst_owner", {31'd0, owner}, 32'd0);
    check("mid_rst_new_accept", {31'd0, bus.req1_ready}, 32'd1);
    @(posedge clk);
    #1 drive(1, 1'b0, OP_ADD, 32'd0, 32'd0);
    drain("mid_rst_drain");

    // Both ports continuously valid with random ops and random response stalls.
    @(posedge clk);
    #1 hs_seen[0] = 1'b0;
    hs_seen[1] = 1'b0;
    g0 = grants;
    rand_stim(0);
    rand_stim(1);
    for (int c = 0; c < 200; c++) begin
      bus.rsp0_ready = ($urandom_range(0, 3) != 0);
      bus.rsp1_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk);
      #1;
      if (hs_seen[0]) begin hs_seen[0] = 1'b0; rand_stim(0); end
      if (hs_seen[1]) begin hs_seen[1] = 1'b0; rand_stim(1); end
    end
    drive(0, 1'b0, OP_ADD, 32'd0, 32'd0);
    drive(1, 1'b0, OP_ADD, 32'd0, 32'd0);
    drain("rand_drain");
    check("rand_enough_grants", {31'd0, (grants - g0) >= 30}, 32'd1);
    check("sb_empty_at_end", sb.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
